bitsliced_slice_sequencer: RTL and testbench

Operand-side driver for the bit-sliced ALU datapath. Accepts a full-width operation request and streams LENGTH/Slice_Size operand slices, with slice indices, into the slice ALU. Collects the returned result slices LSB-first, reassembles the full-width result, and presents it on a valid/ready response port. It sits between the core's register-read stage and the slice ALU.

---
 rtl/bitsliced_slice_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_bitsliced_slice_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitsliced_slice_sequencer.sv
// Operand-side driver for the bit-sliced ALU: streams operand slices out, gathers result
// slices LSB-first and returns the reassembled full-width result on a valid/ready port.
module bitsliced_slice_sequencer #(
  parameter int LENGTH     = 32,
  parameter int Slice_Size = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [LENGTH-1:0]     req_rs1,
  input  logic [LENGTH-1:0]     req_rs2,
  output logic                  slice_valid,
  output logic                  slice_clear,
  output logic [Slice_Size-1:0] rs1_d,
  output logic [Slice_Size-1:0] rs2_d,
  output logic [3:0]            alu_op,
  output logic [31:0]           rs1_cnt,
  output logic [31:0]           rs2_cnt,
  input  logic [Slice_Size-1:0] rd_d,
  input  logic                  rd_valid,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LENGTH-1:0]     resp_rd,
  output logic                  resp_err,
  output logic [1:0]            state_dbg
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where resp_valid && resp_ready. rd_valid
  // has no back-pressure and is consumed only while a result is being collected.

  localparam int N  = LENGTH / Slice_Size;
  localparam int CW = $clog2(N * N + 1);
  localparam logic [CW-1:0] N_C   = CW'(N);
  localparam logic [CW-1:0] NN_C  = CW'(N * N);
  localparam logic [CW-1:0] NM1_C = CW'(N - 1);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [3:0]    OP_MUL = 4'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, RESP} state_t;

  state_t              state_q, state_d;
  logic [LENGTH-1:0]   rs1_q, rs2_q, result_q, result_d;
  logic [CW-1:0]       beat_q, i_q, j_q, got_q, got_d;
  logic [CW-1:0]       i_adv, j_adv, total_beats;
  logic                legal, capture, issue_done, collect_done;

  function automatic logic [Slice_Size-1:0] slice_at(input logic [LENGTH-1:0] v,
                                                     input logic [CW-1:0] idx);
    logic [LENGTH-1:0] sh;
    sh = v >> (idx * Slice_Size);
    return sh[Slice_Size-1:0];
  endfunction

  assign req_ready = (state_q == IDLE) && !reset;
  assign state_dbg = state_q;

  always_comb begin
    legal        = (req_op <= OP_MUL);
    total_beats  = (alu_op == OP_MUL) ? NN_C : N_C;
    // beat_q counts beats already loaded, so equality means the beat on the wire is the last
    issue_done   = (beat_q == total_beats);
    capture      = rd_valid && (state_q == ISSUE || state_q == COLLECT) && (got_q != N_C);
    got_d        = got_q + (capture ? ONE_C : '0);
    result_d     = capture ? {rd_d, result_q[LENGTH-1:Slice_Size]} : result_q;
    collect_done = (got_d == N_C);
    i_adv        = i_q + ONE_C;
    j_adv        = j_q + ONE_C;
    if (alu_op == OP_MUL) begin
      if (j_q == NM1_C) begin
        j_adv = '0;
      end else begin
        i_adv = i_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = legal ? ISSUE : RESP;
      ISSUE:   if (issue_done) state_d = collect_done ? RESP : COLLECT;
      COLLECT: if (collect_done) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      result_q    <= '0;
      beat_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      got_q       <= '0;
      slice_valid <= 1'b0;
      slice_clear <= 1'b0;
      rs1_d       <= '0;
      rs2_d       <= '0;
      alu_op      <= '0;
      rs1_cnt     <= '0;
      rs2_cnt     <= '0;
      resp_valid  <= 1'b0;
      resp_rd     <= '0;
      resp_err    <= 1'b0;
    end else begin
      result_q <= result_d;
      got_q    <= got_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            alu_op   <= req_op;
            rs1_q    <= req_rs1;
            rs2_q    <= req_rs2;
            result_q <= '0;
            got_q    <= '0;
            if (legal) begin
              // Beat 0 goes out straight from the request so it lands the cycle after acceptance
              slice_valid <= 1'b1;
              slice_clear <= 1'b1;
              rs1_d       <= req_rs1[Slice_Size-1:0];
              rs2_d       <= req_rs2[Slice_Size-1:0];
              rs1_cnt     <= '0;
              rs2_cnt     <= '0;
              beat_q      <= ONE_C;
              i_q         <= (req_op == OP_MUL) ? '0 : ONE_C;
              j_q         <= ONE_C;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rd    <= '0;
            end
          end
        end
        ISSUE: begin
          slice_clear <= 1'b0;
          if (issue_done) begin
            slice_valid <= 1'b0;
            if (collect_done) begin
              resp_valid <= 1'b1;
              resp_rd    <= result_d;
            end
          end else begin
            rs1_d   <= slice_at(rs1_q, i_q);
            rs2_d   <= slice_at(rs2_q, j_q);
            rs1_cnt <= 32'(i_q);
            rs2_cnt <= 32'(j_q);
            beat_q  <= beat_q + ONE_C;
            i_q     <= i_adv;
            j_q     <= j_adv;
          end
        end
        COLLECT: begin
          if (collect_done) begin
            resp_valid <= 1'b1;
            resp_rd    <= result_d;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rd    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitsliced_slice_sequencer.sv
// Bench for bitsliced_slice_sequencer: slice-ALU model in the loop, beat and response
// scoreboards fed at request time, directed cases followed by random traffic.
module tb_bitsliced_slice_sequencer;

  localparam int LENGTH = 32;
  localparam int S      = 4;
  localparam int N      = LENGTH / S;
  localparam int W      = LENGTH + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_op = '0;
  logic [LENGTH-1:0] req_rs1 = '0, req_rs2 = '0;
  logic              slice_valid, slice_clear;
  logic [S-1:0]      rs1_d, rs2_d;
  logic [3:0]        alu_op;
  logic [31:0]       rs1_cnt, rs2_cnt;
  logic [S-1:0]      rd_d = '0;
  logic              rd_valid = 1'b0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [LENGTH-1:0] resp_rd;
  logic              resp_err;
  logic [1:0]        state_dbg;

  bitsliced_slice_sequencer #(.LENGTH(LENGTH), .Slice_Size(S)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .slice_valid(slice_valid), .slice_clear(slice_clear), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .alu_op(alu_op), .rs1_cnt(rs1_cnt), .rs2_cnt(rs2_cnt), .rd_d(rd_d), .rd_valid(rd_valid),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd), .resp_err(resp_err),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int k; int i; int j; logic [S-1:0] a; logic [S-1:0] b; logic [3:0] op; } beat_t;
  typedef struct { int rel; logic [S-1:0] d; } rd_t;

  beat_t          beat_q[$];
  logic [W-1:0]   exp_q[$];
  rd_t            alu_q[$];

  int  total = 0, bad = 0;
  int  lat = 1, hold_cnt = 0;
  bit  gaps = 0, extra = 0, rand_ready = 0;
  int  op_start = 0, op_nb = 0, nth_rd_cyc = 0, rd_seen = 0;
  bit  in_resp = 0, post_hs = 0;
  logic [LENGTH-1:0] held_rd;
  logic              held_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference model: whole-word arithmetic
  function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [LENGTH-1:0] a,
                                              input logic [LENGTH-1:0] b);
    logic [LENGTH-1:0] r;
    case (op)
      4'd0:    begin r = a + b; return {1'b0, r}; end
      4'd1:    begin r = a - b; return {1'b0, r}; end
      4'd2:    begin r = a * b; return {1'b0, r}; end
      default: return {1'b1, {LENGTH{1'b0}}};
    endcase
  endfunction

  function automatic int beats_for(input logic [3:0] op);
    return (op == 4'd2) ? N * N : (op < 4'd2) ? N : 0;
  endfunction

  // driver: one request, returns after it has been accepted
  task automatic issue(input logic [3:0] op, input logic [LENGTH-1:0] a, input logic [LENGTH-1:0] b,
                       input int l, input int hold);
    int nb, guard;
    beat_t bt;
    logic [LENGTH-1:0] sa, sb;
    nb = beats_for(op);
    exp_q.push_back(ref_result(op, a, b));
    for (int k = 0; k < nb; k++) begin
      bt.k = k;
      bt.i = (op == 4'd2) ? k / N : k;
      bt.j = (op == 4'd2) ? k % N : k;
      sa = a >> (bt.i * S);
      sb = b >> (bt.j * S);
      bt.a = sa[S-1:0];
      bt.b = sb[S-1:0];
      bt.op = op;
      beat_q.push_back(bt);
    end
    @(posedge clk); #1;
    lat = l;
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
    guard = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      guard++;
      if (guard > 3000) begin
        check("req_accept_timeout", 1, 0);
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 4'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
    hold_cnt = hold;
  endtask

  task automatic flush();
    beat_q.delete(); exp_q.delete(); alu_q.delete();
    in_resp = 0; post_hs = 0; rd_seen = 0;
  endtask

  // slice ALU model: consumes observed beats, queues result slices with latency
  logic              carry;
  logic [LENGTH-1:0] acc;
  always @(negedge clk) begin
    logic [S:0]        t;
    logic [LENGTH-1:0] pp;
    int                sh;
    rd_t               r;
    if (slice_valid && !reset) begin
      if (slice_clear) begin carry = 1'b0; acc = '0; end
      r.rel = cyc + lat;
      case (alu_op)
        4'd0: begin
          t = {1'b0, rs1_d} + {1'b0, rs2_d} + {{S{1'b0}}, carry};
          carry = t[S]; r.d = t[S-1:0]; alu_q.push_back(r);
        end
        4'd1: begin
          t = {1'b0, rs1_d} - {1'b0, rs2_d} - {{S{1'b0}}, carry};
          carry = t[S]; r.d = t[S-1:0]; alu_q.push_back(r);
        end
        4'd2: begin
          pp = LENGTH'(rs1_d) * LENGTH'(rs2_d);
          sh = (int'(rs1_cnt) + int'(rs2_cnt)) * S;
          if (sh < LENGTH) acc = acc + (pp << sh);
          if (rs1_cnt == 32'(N - 1) && rs2_cnt == 32'(N - 1)) begin
            for (int k = 0; k < N; k++) begin
              pp = acc >> (k * S);
              r.d = pp[S-1:0];
              alu_q.push_back(r);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // rd driver: releases ALU slices, optionally with gaps and junk beats while nothing is collected
  initial begin
    forever begin
      @(posedge clk); #1;
      rd_valid = 1'b0;
      rd_d = S'($urandom);
      if (alu_q.size() > 0 && alu_q[0].rel <= cyc && (!gaps || $urandom_range(0, 2) != 0)) begin
        rd_t r;
        r = alu_q.pop_front();
        rd_valid = 1'b1; rd_d = r.d;
        rd_seen++;
        if (rd_seen == N) nth_rd_cyc = cyc;
      end else if (extra && (resp_valid || req_ready) && $urandom_range(0, 1) == 1) begin
        rd_valid = 1'b1;
      end
    end
  end

  // resp_ready driver
  initial begin
    forever begin
      @(posedge clk); #2;
      if (resp_valid) begin
        if (hold_cnt > 0) begin resp_ready = 1'b0; hold_cnt--; end
        else resp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        resp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // monitor: beats, responses, acceptance bookkeeping
  always @(negedge clk) begin
    beat_t b;
    logic [W-1:0] e;
    int exp_cyc, last_beat;
    if (!reset) begin
      if (slice_valid) begin
        if (beat_q.size() == 0) check("spurious_beat", 1, 0);
        else begin
          b = beat_q.pop_front();
          check("beat_cycle", cyc, op_start + b.k);
          check("beat_clear", slice_clear, (b.k == 0));
          check("beat_rs1_cnt", rs1_cnt, b.i);
          check("beat_rs2_cnt", rs2_cnt, b.j);
          check("beat_rs1_d", rs1_d, b.a);
          check("beat_rs2_d", rs2_d, b.b);
          check("beat_alu_op", alu_op, b.op);
        end
      end
      if (resp_valid) begin
        if (!in_resp) begin
          in_resp = 1;
          if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("resp_rd", resp_rd, e[LENGTH-1:0]);
            check("resp_err", resp_err, e[LENGTH]);
            last_beat = op_start + op_nb - 1;
            exp_cyc = (op_nb == 0) ? op_start :
                      ((last_beat > nth_rd_cyc) ? last_beat : nth_rd_cyc) + 1;
            check("resp_cycle", cyc, exp_cyc);
          end
          held_rd = resp_rd; held_err = resp_err;
        end else begin
          check("resp_rd_stable", resp_rd, held_rd);
          check("resp_err_stable", resp_err, held_err);
        end
        check("req_ready_in_resp", req_ready, 0);
        if (resp_ready) begin in_resp = 0; post_hs = 1; end
      end else if (post_hs) begin
        post_hs = 0;
        check("req_ready_after_hs", req_ready, 1);
      end
      if (req_valid && req_ready) begin
        op_start = cyc + 1;
        op_nb = beats_for(req_op);
        rd_seen = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_slice"}, {slice_valid, slice_clear, rs1_d, rs2_d, alu_op}, 0);
    check({tag, "_cnts"}, {rs1_cnt, rs2_cnt}, 0);
    check({tag, "_resp"}, {resp_valid, resp_err, resp_rd}, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // stimulus
  initial begin
    int guard;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    issue(4'd0, 32'h0000FFFF, 32'h00000001, 1, 0);
    issue(4'd1, 32'd5, 32'd7, 3, 0);
    issue(4'd2, 32'h00001234, 32'h00000010, 2, 0);
    issue(4'd4, $urandom, $urandom, 1, 0);
    extra = 1;
    issue(4'd0, $urandom, $urandom, 1, 5);

    // reset in the middle of an add at beat 3
    issue(4'd0, $urandom, $urandom, 1, 0);
    guard = 0;
    forever begin
      @(negedge clk);
      if (slice_valid && rs1_cnt == 32'd3) break;
      guard++;
      if (guard > 200) begin check("beat3_timeout", 1, 0); break; end
    end
    #1 reset = 1'b1;
    #1 check_all_zero("abort");
    flush();
    @(posedge clk); #1;
    check_all_zero("abort_hold");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", req_ready, 1);
    issue(4'd0, 32'h0000FFFF, 32'h00000001, 1, 0);

    // random traffic
    gaps = 1; rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [3:0] op;
      r = $urandom_range(0, 9);
      op = (r < 8) ? 4'(r % 3) : 4'($urandom_range(3, 15));
      issue(op, $urandom, $urandom, $urandom_range(1, 4), $urandom_range(0, 3));
    end

    guard = 0;
    while ((exp_q.size() != 0 || in_resp || post_hs) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("exp_left", exp_q.size(), 0);
    check("beats_left", beat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    total++; bad++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
